// File: rtl/pcie_rx_tlp_router.sv
// RX TLP router: steers whole packets by BAR hit to two egress streams, each
// behind its own 2-entry skid buffer; unmapped BARs are dropped and counted.

module pcie_rx_tlp_router_skid #(
    parameter int unsigned W = 514
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    output logic         o_full,
    output logic         o_valid,
    output logic [W-1:0] o_dout,
    input  logic         i_ready
);
    logic [W-1:0] r_mem [2];
    logic         r_wr;
    logic         r_rd;
    logic [1:0]   r_cnt;
    logic         w_pop;

    assign w_pop   = o_valid & i_ready;
    assign o_full  = (r_cnt == 2'd2);
    assign o_valid = (r_cnt != 2'd0);
    assign o_dout  = r_mem[r_rd];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr  <= 1'b0;
            r_rd  <= 1'b0;
            r_cnt <= '0;
        end else begin
            if (i_push) r_wr <= ~r_wr;
            if (w_pop)  r_rd <= ~r_rd;
            r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, w_pop};
        end
    end

    // Payload storage needs no reset; occupancy alone qualifies it.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr] <= i_din;
    end
endmodule

module pcie_rx_tlp_router #(
    parameter int unsigned DATA_W    = 512,
    parameter int unsigned BAR_W     = 3,
    parameter int unsigned PORT0_BAR = 0,
    parameter int unsigned PORT1_BAR = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              fim_clk,
    input  logic              fim_rst,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic [DATA_W-1:0] in_data,
    input  logic [BAR_W-1:0]  in_bar,
    output logic              in_ready,
    output logic              out0_valid,
    output logic              out0_sop,
    output logic              out0_eop,
    output logic [DATA_W-1:0] out0_data,
    input  logic              out0_ready,
    output logic              out1_valid,
    output logic              out1_sop,
    output logic              out1_eop,
    output logic [DATA_W-1:0] out1_data,
    input  logic              out1_ready,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              err_pulse
);
    typedef enum logic [1:0] {IDLE, FWD0, FWD1, DROP} state_t;

    localparam logic [BAR_W-1:0] P0 = BAR_W'(PORT0_BAR);
    localparam logic [BAR_W-1:0] P1 = BAR_W'(PORT1_BAR);

    state_t r_state, w_next, w_sop_dest, w_dest;
    logic   w_full0, w_full1, w_acc, w_push0, w_push1, w_err, w_drop;
    logic [CNT_W-1:0] r_drop_cnt, r_err_cnt;
    logic             r_err_pulse;

    // A sop beat is always re-decoded, even mid-packet, so its destination
    // (not the latched one) decides both routing and in_ready.
    always_comb begin
        w_sop_dest = DROP;
        if (in_bar == P0)      w_sop_dest = FWD0;
        else if (in_bar == P1) w_sop_dest = FWD1;
        w_dest = in_sop ? w_sop_dest : r_state;
    end

    always_comb begin
        in_ready = 1'b1;
        case (w_dest)
            FWD0:    in_ready = ~w_full0;
            FWD1:    in_ready = ~w_full1;
            default: in_ready = 1'b1;
        endcase
        if (fim_rst) in_ready = 1'b0;
    end

    assign w_acc   = in_valid & in_ready;
    assign w_push0 = w_acc & (w_dest == FWD0);
    assign w_push1 = w_acc & (w_dest == FWD1);
    assign w_err   = w_acc & (in_sop ? (r_state != IDLE) : (r_state == IDLE));
    assign w_drop  = w_acc & in_sop & (w_sop_dest == DROP);

    always_comb begin
        w_next = r_state;
        if (w_acc) begin
            if ((w_dest == IDLE) || in_eop) w_next = IDLE;
            else                            w_next = w_dest;
        end
    end

    always_ff @(posedge fim_clk or posedge fim_rst) begin
        if (fim_rst) begin
            r_state     <= IDLE;
            r_drop_cnt  <= '0;
            r_err_cnt   <= '0;
            r_err_pulse <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_err_pulse <= w_err;
            if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
            if (w_err && (r_err_cnt != '1))   r_err_cnt  <= r_err_cnt + 1'b1;
        end
    end

    assign drop_cnt  = r_drop_cnt;
    assign err_cnt   = r_err_cnt;
    assign err_pulse = r_err_pulse;

    pcie_rx_tlp_router_skid #(.W(DATA_W + 2)) u_skid0 (
        .clk     (fim_clk),
        .rst     (fim_rst),
        .i_push  (w_push0),
        .i_din   ({in_sop, in_eop, in_data}),
        .o_full  (w_full0),
        .o_valid (out0_valid),
        .o_dout  ({out0_sop, out0_eop, out0_data}),
        .i_ready (out0_ready)
    );

    pcie_rx_tlp_router_skid #(.W(DATA_W + 2)) u_skid1 (
        .clk     (fim_clk),
        .rst     (fim_rst),
        .i_push  (w_push1),
        .i_din   ({in_sop, in_eop, in_data}),
        .o_full  (w_full1),
        .o_valid (out1_valid),
        .o_dout  ({out1_sop, out1_eop, out1_data}),
        .i_ready (out1_ready)
    );
endmodule

// File: tb/tb_pcie_rx_tlp_router.sv
// Bench for pcie_rx_tlp_router: directed scenarios plus random traffic checked
// against a packet-level reference model (per-port expected-beat queues).

module tb_pcie_rx_tlp_router;
    localparam int DW = 64;
    localparam int BW = 3;
    localparam int CW = 8;
    localparam int CMAX = (1 << CW) - 1;

    typedef logic [DW+1:0] beat_t;

    logic          fim_clk, fim_rst;
    logic          in_valid, in_sop, in_eop, in_ready;
    logic [DW-1:0] in_data;
    logic [BW-1:0] in_bar;
    logic          out0_valid, out0_sop, out0_eop, out0_ready;
    logic [DW-1:0] out0_data;
    logic          out1_valid, out1_sop, out1_eop, out1_ready;
    logic [DW-1:0] out1_data;
    logic [CW-1:0] drop_cnt, err_cnt;
    logic          err_pulse;

    pcie_rx_tlp_router #(
        .DATA_W(DW), .BAR_W(BW), .PORT0_BAR(0), .PORT1_BAR(2), .CNT_W(CW)
    ) dut (
        .fim_clk(fim_clk), .fim_rst(fim_rst),
        .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
        .in_data(in_data), .in_bar(in_bar), .in_ready(in_ready),
        .out0_valid(out0_valid), .out0_sop(out0_sop), .out0_eop(out0_eop),
        .out0_data(out0_data), .out0_ready(out0_ready),
        .out1_valid(out1_valid), .out1_sop(out1_sop), .out1_eop(out1_eop),
        .out1_data(out1_data), .out1_ready(out1_ready),
        .drop_cnt(drop_cnt), .err_cnt(err_cnt), .err_pulse(err_pulse)
    );

    initial fim_clk = 1'b0;
    always #5 fim_clk = ~fim_clk;

    int    n_vec = 0, n_err = 0;
    beat_t q0[$], q1[$];
    int    cur = -1;         // -1: between packets, 0/1: port, 2: dropping
    int    m_drop = 0, m_err = 0, n_pulse = 0, cyc = 0;
    bit    m_pulse = 0, accepted = 0, rand_rdy = 0;

    task automatic chk(input string tag, input logic [DW+1:0] got, input logic [DW+1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int decode(input logic [BW-1:0] b);
        if (b == 0) return 0;
        if (b == 2) return 1;
        return 2;
    endfunction

    task automatic model_err();
        if (m_err < CMAX) m_err++;
        m_pulse = 1;
    endtask

    task automatic model_reset();
        q0.delete(); q1.delete();
        cur = -1; m_drop = 0; m_err = 0; m_pulse = 0;
    endtask

    // One clock: compare at the negedge, update the model with the handshakes
    // that take effect at the following posedge, return at posedge+1.
    task automatic step();
        int    dest;
        bit    exp_rdy;
        beat_t b;
        @(negedge fim_clk);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("err_cnt", err_cnt, m_err);
        chk("err_pulse", err_pulse, m_pulse);
        if (err_pulse) n_pulse++;
        dest    = in_sop ? decode(in_bar) : cur;
        exp_rdy = (dest == 0) ? (q0.size() < 2) : (dest == 1) ? (q1.size() < 2) : 1'b1;
        chk("in_ready", in_ready, exp_rdy);
        chk("out0_valid", out0_valid, q0.size() != 0);
        chk("out1_valid", out1_valid, q1.size() != 0);
        if (out0_valid && q0.size() != 0) begin
            chk("out0_beat", {out0_sop, out0_eop, out0_data}, q0[0]);
            if (out0_ready) void'(q0.pop_front());
        end
        if (out1_valid && q1.size() != 0) begin
            chk("out1_beat", {out1_sop, out1_eop, out1_data}, q1[0]);
            if (out1_ready) void'(q1.pop_front());
        end
        m_pulse  = 0;
        accepted = in_valid && in_ready;
        b = {in_sop, in_eop, in_data};
        if (accepted) begin
            if (in_sop) begin
                if (cur != -1) model_err();
                dest = decode(in_bar);
                if (dest == 2 && m_drop < CMAX) m_drop++;
                if (dest == 0) q0.push_back(b);
                if (dest == 1) q1.push_back(b);
                cur = in_eop ? -1 : dest;
            end else if (cur == -1) begin
                model_err();
            end else begin
                if (cur == 0) q0.push_back(b);
                if (cur == 1) q1.push_back(b);
                if (in_eop) cur = -1;
            end
        end
        cyc++;
        @(posedge fim_clk);
        #1;
    endtask

    task automatic push_beat(input bit sop, input bit eop, input logic [BW-1:0] bar);
        in_valid = 1; in_sop = sop; in_eop = eop; in_bar = bar;
        in_data = {$urandom, $urandom};
        accepted = 0;
        for (int t = 0; t < 100; t++) begin
            if (rand_rdy) begin
                out0_ready = ($urandom % 4) != 0;
                out1_ready = ($urandom % 4) != 0;
            end
            step();
            if (accepted) break;
        end
        if (!accepted) chk("accept_timeout", 0, 1);
        in_valid = 0; in_sop = 0; in_eop = 0;
    endtask

    task automatic send_pkt(input logic [BW-1:0] bar, input int len);
        for (int i = 0; i < len; i++) push_beat(i == 0, i == len - 1, bar);
    endtask

    task automatic drain();
        in_valid = 0; in_sop = 0; in_eop = 0;
        out0_ready = 1; out1_ready = 1;
        repeat (6) step();
    endtask

    task automatic apply_reset();
        in_valid = 0; in_sop = 0; in_eop = 0;
        fim_rst = 1;
        model_reset();
        @(posedge fim_clk);
        @(negedge fim_clk);
        fim_rst = 0;
        @(posedge fim_clk);
        #1;
    endtask

    initial begin
        int c0;
        in_valid = 0; in_sop = 0; in_eop = 0; in_data = '0; in_bar = '0;
        out0_ready = 1; out1_ready = 1;
        fim_rst = 1;
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out0_valid", out0_valid, 0);
        chk("rst_out1_valid", out1_valid, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_err_pulse", err_pulse, 0);
        apply_reset();

        // Back-to-back 4-beat packets, consumers always ready.
        c0 = cyc;
        send_pkt(0, 4); send_pkt(2, 4); send_pkt(0, 4);
        chk("b2b_cycles", cyc - c0, 12);
        drain();
        chk("b2b_drop_cnt", drop_cnt, 0);

        // Single-beat drop then single-beat route.
        apply_reset();
        push_beat(1, 1, 5);
        push_beat(1, 1, 0);
        drain();
        chk("single_drop_cnt", drop_cnt, 1);
        chk("single_err_cnt", err_cnt, 0);

        // Port 0 stalled: third beat blocks the ingress, port 1 starves.
        apply_reset();
        out0_ready = 0; out1_ready = 1;
        push_beat(1, 0, 0);
        push_beat(0, 0, 0);
        in_valid = 1; in_sop = 0; in_eop = 1; in_data = {$urandom, $urandom};
        repeat (4) begin
            step();
            chk("stall_blocked", accepted, 0);
        end
        out0_ready = 1;
        push_beat(0, 1, 0);
        send_pkt(2, 2);
        drain();

        // Port 1 stalled: port 0 traffic unimpeded.
        apply_reset();
        out0_ready = 1; out1_ready = 0;
        send_pkt(2, 2);
        c0 = cyc;
        send_pkt(0, 3);
        chk("p1_stall_p0_cycles", cyc - c0, 3);
        drain();

        // Framing errors: stray non-sop in IDLE, sop mid-packet.
        apply_reset();
        n_pulse = 0;
        push_beat(0, 1, 0);
        push_beat(1, 0, 0);
        push_beat(0, 0, 0);
        push_beat(1, 0, 2);
        push_beat(0, 1, 0);
        drain();
        chk("frm_err_cnt", err_cnt, 2);
        chk("frm_pulses", n_pulse, 2);

        // Asynchronous reset mid-packet.
        apply_reset();
        push_beat(1, 1, 5);
        push_beat(0, 1, 0);
        out0_ready = 0;
        push_beat(1, 0, 0);
        step();
        in_valid = 1; in_sop = 1; in_bar = 0;
        fim_rst = 1;
        #1;
        chk("arst_out0_valid", out0_valid, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_drop_cnt", drop_cnt, 0);
        chk("arst_err_cnt", err_cnt, 0);
        chk("arst_err_pulse", err_pulse, 0);
        in_valid = 0; in_sop = 0;
        model_reset();
        @(negedge fim_clk);
        fim_rst = 0;
        @(posedge fim_clk);
        #1;
        out0_ready = 1;
        push_beat(0, 1, 0);
        send_pkt(0, 2);
        drain();

        // Drop counter saturation.
        apply_reset();
        repeat (CMAX - 1) push_beat(1, 1, 5);
        chk("sat_pre", drop_cnt, CMAX - 1);
        repeat (3) push_beat(1, 1, 5);
        step();
        chk("sat_drop_cnt", drop_cnt, CMAX);

        // Random traffic with random consumer back-pressure.
        apply_reset();
        rand_rdy = 1;
        for (int p = 0; p < 300; p++) begin
            logic [BW-1:0] bar;
            int len, r;
            bar = ($urandom % 2) ? (($urandom % 2) ? 3'd0 : 3'd2) : BW'($urandom % 8);
            len = 1 + ($urandom % 4);
            r   = $urandom % 20;
            if (r == 0) push_beat(0, $urandom % 2, bar);
            for (int i = 0; i < len; i++)
                push_beat(i == 0, (i == len - 1) && (r != 1), bar);
            if ($urandom % 3 == 0) step();
        end
        rand_rdy = 0;
        drain();
        chk("rand_q0_empty", q0.size(), 0);
        chk("rand_q1_empty", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
